canvas_feature_scan: RTL and testbench

CANVAS_FEATURE_SCAN -- requirements
Module: canvas_feature_scan

---
 rtl/canvas_feature_scan.sv | 200 ++++++++++++++++++++
 tb/tb_canvas_feature_scan.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/canvas_feature_scan.sv
// Raster-scans a 1-bit canvas, counting set pixels and (with CANVAS_BBOX_EN defined)
// tracking their bounding box; the result is held until the consumer accepts it.
module canvas_feature_scan #(
    parameter int CANVAS_W = 32,
    parameter int CANVAS_H = 32,
    parameter int RD_LAT   = 1,
    localparam int AW = $clog2(CANVAS_W * CANVAS_H),
    localparam int XW = $clog2(CANVAS_W),
    localparam int YW = $clog2(CANVAS_H),
    localparam int CW = $clog2(CANVAS_W * CANVAS_H + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_start,
    input  logic          abort,
    input  logic          read_data,
    output logic [AW-1:0] read_addr,
    output logic          read_enable,
    output logic          pending,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [CW-1:0] ink_count,
    output logic          empty,
    output logic [XW-1:0] bbox_x0,
    output logic [XW-1:0] bbox_x1,
    output logic [YW-1:0] bbox_y0,
    output logic [YW-1:0] bbox_y1
);
    localparam int NPIX = CANVAS_W * CANVAS_H;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      drain_q, drain_d;
    logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
    logic [CW-1:0]   ink_q, ink_d;
    logic            hit;

`ifdef CANVAS_BBOX_EN
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] pipe_x_q [RD_LAT];
    logic [XW-1:0] pipe_x_d [RD_LAT];
    logic [YW-1:0] pipe_y_q [RD_LAT];
    logic [YW-1:0] pipe_y_d [RD_LAT];
    logic [XW-1:0] bx0_q, bx0_d, bx1_q, bx1_d;
    logic [YW-1:0] by0_q, by0_d, by1_q, by1_d;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
`endif

    assign read_enable  = (state_q == READ);
    assign read_addr    = read_enable ? addr_q : '0;
    assign pending      = (state_q == READ) || (state_q == DRAIN);
    assign result_valid = (state_q == DONE);
    assign ink_count    = ink_q;
    assign empty        = (ink_q == '0);
    // Returning pixels are only counted while a scan is live, so stale data after abort is dropped.
    assign hit          = pipe_v_q[RD_LAT-1] && read_data && pending && !abort;

`ifdef CANVAS_BBOX_EN
    assign px      = pipe_x_q[RD_LAT-1];
    assign py      = pipe_y_q[RD_LAT-1];
    assign bbox_x0 = bx0_q;
    assign bbox_x1 = bx1_q;
    assign bbox_y0 = by0_q;
    assign bbox_y1 = by1_q;
`else
    assign bbox_x0 = '0;
    assign bbox_x1 = XW'(CANVAS_W - 1);
    assign bbox_y0 = '0;
    assign bbox_y1 = YW'(CANVAS_H - 1);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        ink_d   = ink_q;
        pipe_v_d[0] = (state_q == READ);
        for (int i = 1; i < RD_LAT; i++) pipe_v_d[i] = pipe_v_q[i-1];
        if (state_q == IDLE) pipe_v_d = '0;
`ifdef CANVAS_BBOX_EN
        x_d   = x_q;
        y_d   = y_q;
        bx0_d = bx0_q;
        bx1_d = bx1_q;
        by0_d = by0_q;
        by1_d = by1_q;
        pipe_x_d[0] = x_q;
        pipe_y_d[0] = y_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_x_d[i] = pipe_x_q[i-1];
            pipe_y_d[i] = pipe_y_q[i-1];
        end
`endif
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    state_d = READ;
                    addr_d  = '0;
                    ink_d   = '0;
`ifdef CANVAS_BBOX_EN
                    x_d   = '0;
                    y_d   = '0;
                    bx0_d = '0;
                    bx1_d = '0;
                    by0_d = '0;
                    by1_d = '0;
`endif
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (addr_q == AW'(NPIX - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
`ifdef CANVAS_BBOX_EN
                if (x_q == XW'(CANVAS_W - 1)) begin
                    x_d = '0;
                    y_d = y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
`endif
            end
            DRAIN: begin
                if (abort) state_d = IDLE;
                else if (drain_q == 3'(RD_LAT - 1)) state_d = DONE;
                else drain_d = drain_q + 3'd1;
            end
            DONE: begin
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (hit) begin
            ink_d = ink_q + CW'(1);
`ifdef CANVAS_BBOX_EN
            // First set pixel seeds the box; later pixels only widen it.
            if (ink_q == '0) begin
                bx0_d = px;
                bx1_d = px;
                by0_d = py;
                by1_d = py;
            end else begin
                if (px < bx0_q) bx0_d = px;
                if (px > bx1_q) bx1_d = px;
                if (py < by0_q) by0_d = py;
                if (py > by1_q) by1_d = py;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            drain_q  <= '0;
            pipe_v_q <= '0;
            ink_q    <= '0;
`ifdef CANVAS_BBOX_EN
            x_q   <= '0;
            y_q   <= '0;
            bx0_q <= '0;
            bx1_q <= '0;
            by0_q <= '0;
            by1_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_x_q[i] <= '0;
                pipe_y_q[i] <= '0;
            end
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
            pipe_v_q <= pipe_v_d;
            ink_q    <= ink_d;
`ifdef CANVAS_BBOX_EN
            x_q      <= x_d;
            y_q      <= y_d;
            bx0_q    <= bx0_d;
            bx1_q    <= bx1_d;
            by0_q    <= by0_d;
            by1_q    <= by1_d;
            pipe_x_q <= pipe_x_d;
            pipe_y_q <= pipe_y_d;
`endif
        end
    end
endmodule

// File: tb/tb_canvas_feature_scan.sv
// Drives a 32x32/RD_LAT=1 instance and a 16x8/RD_LAT=2 instance in lockstep from
// shared controls, comparing each against a canvas-level reference model.
module tb_canvas_feature_scan;
    localparam int NA = 1024;
    localparam int NB = 128;

    logic clk = 1'b0;
    logic rst, in_start, abort, result_ready;
    always #5 clk = ~clk;

    logic       rd_a, re_a, pend_a, rv_a, empty_a;
    logic [9:0] addr_a;
    logic [10:0] ink_a;
    logic [4:0] x0_a, x1_a, y0_a, y1_a;

    logic       rd_b, rd_b_p1, re_b, pend_b, rv_b, empty_b;
    logic [6:0] addr_b;
    logic [7:0] ink_b;
    logic [3:0] x0_b, x1_b;
    logic [2:0] y0_b, y1_b;

    canvas_feature_scan dut_a (
        .clk(clk), .rst(rst), .in_start(in_start), .abort(abort), .read_data(rd_a),
        .read_addr(addr_a), .read_enable(re_a), .pending(pend_a), .result_valid(rv_a),
        .result_ready(result_ready), .ink_count(ink_a), .empty(empty_a),
        .bbox_x0(x0_a), .bbox_x1(x1_a), .bbox_y0(y0_a), .bbox_y1(y1_a)
    );

    canvas_feature_scan #(.CANVAS_W(16), .CANVAS_H(8), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .in_start(in_start), .abort(abort), .read_data(rd_b),
        .read_addr(addr_b), .read_enable(re_b), .pending(pend_b), .result_valid(rv_b),
        .result_ready(result_ready), .ink_count(ink_b), .empty(empty_b),
        .bbox_x0(x0_b), .bbox_x1(x1_b), .bbox_y0(y0_b), .bbox_y1(y1_b)
    );

    bit canvas [2][1024];
    int checks = 0;
    int errors = 0;

    // Canvas memories; junk is returned for cycles with no read issued.
    always @(posedge clk) begin
        rd_a    <= re_a ? canvas[0][addr_a] : 1'($urandom);
        rd_b_p1 <= re_b ? canvas[1][addr_b] : 1'($urandom);
        rd_b    <= rd_b_p1;
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int s, output int cnt, output int x0, output int x1,
                                  output int y0, output int y1);
        int w, h;
        w = (s != 0) ? 16 : 32;
        h = (s != 0) ? 8 : 32;
        cnt = 0; x0 = w; x1 = -1; y0 = h; y1 = -1;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                if (canvas[s][y*w + x]) begin
                    cnt++;
                    if (x < x0) x0 = x;
                    if (x > x1) x1 = x;
                    if (y < y0) y0 = y;
                    if (y > y1) y1 = y;
                end
`ifdef CANVAS_BBOX_EN
        if (cnt == 0) begin x0 = 0; x1 = 0; y0 = 0; y1 = 0; end
`else
        x0 = 0; x1 = w - 1; y0 = 0; y1 = h - 1;
`endif
    endfunction

    task automatic check_result(string tag);
        int c, x0, x1, y0, y1;
        model(0, c, x0, x1, y0, y1);
        check({tag, "/A ink"}, 32'(ink_a), c);
        check({tag, "/A empty"}, 32'(empty_a), (c == 0) ? 1 : 0);
        check({tag, "/A x0"}, 32'(x0_a), x0);
        check({tag, "/A x1"}, 32'(x1_a), x1);
        check({tag, "/A y0"}, 32'(y0_a), y0);
        check({tag, "/A y1"}, 32'(y1_a), y1);
        model(1, c, x0, x1, y0, y1);
        check({tag, "/B ink"}, 32'(ink_b), c);
        check({tag, "/B empty"}, 32'(empty_b), (c == 0) ? 1 : 0);
        check({tag, "/B x0"}, 32'(x0_b), x0);
        check({tag, "/B x1"}, 32'(x1_b), x1);
        check({tag, "/B y0"}, 32'(y0_b), y0);
        check({tag, "/B y1"}, 32'(y1_b), y1);
    endtask

    // Starts a scan and follows it cycle by cycle; abort_at>0 aborts in that READ cycle.
    task automatic run_scan(string tag, int abort_at);
        int lat_a = 0, lat_b = 0, seq_err = 0;
        bit run, ere;
        @(negedge clk);
        in_start = 1'b1;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            in_start = 1'b0;
            run = (abort_at == 0) || (k <= abort_at);
            ere = run && (k <= NA);
            if (re_a !== ere || addr_a !== (ere ? 10'(k-1) : 10'd0) ||
                pend_a !== (run && k <= NA + 1)) seq_err++;
            ere = run && (k <= NB);
            if (re_b !== ere || addr_b !== (ere ? 7'(k-1) : 7'd0) ||
                pend_b !== (run && k <= NB + 2)) seq_err++;
            if (rv_a === 1'b1 && lat_a == 0) lat_a = k;
            if (rv_b === 1'b1 && lat_b == 0) lat_b = k;
            abort = (abort_at > 0 && k == abort_at);
            if (abort_at > 0 && k >= abort_at + 20) break;
            if (lat_a != 0 && lat_b != 0) break;
        end
        abort = 1'b0;
        check({tag, " seq"}, seq_err, 0);
        if (abort_at > 0) begin
            check({tag, "/A no valid"}, lat_a, 0);
            check({tag, "/B no valid"}, lat_b, 0);
        end else begin
            check({tag, "/A latency"}, lat_a, 1 + NA + 1);
            check({tag, "/B latency"}, lat_b, 1 + NB + 2);
            check_result(tag);
        end
        $display("scan %s: A ink=%0d lat=%0d | B ink=%0d lat=%0d", tag, ink_a, lat_a, ink_b, lat_b);
    endtask

    task automatic handshake(string tag);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, "/A valid drop"}, 32'(rv_a), 0);
        check({tag, "/B valid drop"}, 32'(rv_b), 0);
    endtask

    task automatic fill(int dens_a, int dens_b);
        for (int i = 0; i < NA; i++) canvas[0][i] = ($urandom_range(99) < dens_a);
        for (int i = 0; i < 1024; i++) canvas[1][i] = (i < NB) && ($urandom_range(99) < dens_b);
    endtask

    initial begin
        int held_err;
        rst = 1'b1; in_start = 1'b0; abort = 1'b0; result_ready = 1'b0;
        fill(0, 0);
        repeat (3) @(negedge clk);
        // Reset state
        check("reset/A valid", 32'(rv_a), 0);
        check("reset/A pending", 32'(pend_a), 0);
        check("reset/A enable", 32'(re_a), 0);
        check("reset/A addr", 32'(addr_a), 0);
        check("reset/B valid", 32'(rv_b), 0);
        check_result("reset");
        rst = 1'b0;

        run_scan("blank", 0);
        handshake("blank");

        fill(0, 0);
        canvas[0][229] = 1'b1;
        canvas[1][0] = 1'b1;
        canvas[1][127] = 1'b1;
        run_scan("single", 0);
        handshake("single");

        fill(100, 100);
        run_scan("full", 0);
        handshake("full");

        fill(30, 30);
        run_scan("abort", 100);
        run_scan("after-abort", 0);
        handshake("after-abort");

        for (int r = 0; r < 3; r++) begin
            fill(1 + 10 * r, 2 + 5 * r);
            run_scan($sformatf("rand%0d", r), 0);
            handshake($sformatf("rand%0d", r));
        end

        // Result held across a stalled consumer with a stray start pulse
        fill(5, 10);
        run_scan("hold", 0);
        held_err = 0;
        for (int i = 0; i < 10; i++) begin
            in_start = (i == 3);
            @(negedge clk);
            if (rv_a !== 1'b1 || rv_b !== 1'b1 || pend_a !== 1'b0 || pend_b !== 1'b0) held_err++;
        end
        in_start = 1'b0;
        check("hold stall", held_err, 0);
        check_result("hold");
        handshake("hold");
        @(negedge clk);
        check("hold/A idle pending", 32'(pend_a), 0);

        // Reset in the middle of a scan discards the partial result
        fill(100, 100);
        @(negedge clk); in_start = 1'b1;
        @(negedge clk); in_start = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset/A pending", 32'(pend_a), 0);
        check("midreset/A ink", 32'(ink_a), 0);
        check("midreset/A empty", 32'(empty_a), 1);
        check("midreset/B ink", 32'(ink_b), 0);
        check("midreset/B enable", 32'(re_b), 0);
        fill(50, 50);
        run_scan("post-reset", 0);
        handshake("post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
